// File: rtl/char_buffer_reader_pkg.sv
// Constants and FSM encoding shared by the character buffer reader and the
// host write path that fills the same RAM window.
package char_buffer_reader_pkg;

    localparam int CHAR_BUF_BASE = 1500;
    localparam int CHAR_BUF_LEN  = 108;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_REQ  = 3'd1;
    localparam state_t ST_WAIT = 3'd2;
    localparam state_t ST_SEND = 3'd3;
    localparam state_t ST_FIN  = 3'd4;

    function automatic logic [7:0] last_index(input int len);
        return 8'(len - 1);
    endfunction

endpackage

// File: rtl/char_buffer_reader_char_out_reg.sv
// Output holding register for the character stream: data, index and valid.
// load captures a new character and raises valid; clear drops valid only.
module char_out_reg (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic       clear_i,
    input  logic [7:0] data_i,
    input  logic [7:0] index_i,
    output logic [7:0] char_data_o,
    output logic [7:0] char_index_o,
    output logic       char_valid_o
);

    logic [7:0] data_q;
    logic [7:0] index_q;
    logic       valid_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q  <= 8'h00;
            index_q <= 8'h00;
            valid_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            index_q <= index_i;
            valid_q <= 1'b1;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end
    end

    assign char_data_o  = data_q;
    assign char_index_o = index_q;
    assign char_valid_o = valid_q;

endmodule

// File: rtl/char_buffer_reader.sv
// Drains the decrypted character buffer from processor RAM as a byte stream.
// Defining CHAR_READER_NUL_STOP_EN ends the drain at the first NUL byte.
module char_buffer_reader
    import char_buffer_reader_pkg::*;
#(
    parameter int BASE_ADDR = CHAR_BUF_BASE,
    parameter int BUF_LEN   = CHAR_BUF_LEN,
    parameter int ADDR_W    = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [31:0]       ram_data,
    output logic [7:0]        char_data,
    output logic              char_valid,
    input  logic              char_ready,
    output logic [7:0]        char_index,
    output logic [2:0]        dbg_state
);

    // char_valid/char_ready: a character transfers on a rising edge where both
    // are high; once raised, char_valid stays high and char_data/char_index
    // stay unchanged until that transfer happens.

    state_t     state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic       load;
    logic       handshake;
    logic       nul_stop;
    logic       unused_ram_hi;

    assign handshake = (state_q == ST_SEND) && char_valid && char_ready;

`ifdef CHAR_READER_NUL_STOP_EN
    assign nul_stop = (ram_data[7:0] == 8'h00);
`else
    assign nul_stop = 1'b0;
`endif

    // Only the low byte of each RAM word carries a character.
    assign unused_ram_hi = ^ram_data[31:8];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                idx_d = 8'h00;
                if (start) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (nul_stop) begin
                    state_d = ST_FIN;
                end else begin
                    load    = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (handshake) begin
                    if (idx_q == last_index(BUF_LEN)) begin
                        state_d = ST_FIN;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_FIN: begin
                idx_d   = 8'h00;
                state_d = ST_IDLE;
            end
            default: begin
                idx_d   = 8'h00;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            idx_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    char_out_reg u_out (
        .clk_i        (clock),
        .rst_ni       (reset),
        .load_i       (load),
        .clear_i      (handshake),
        .data_i       (ram_data[7:0]),
        .index_i      (idx_q),
        .char_data_o  (char_data),
        .char_index_o (char_index),
        .char_valid_o (char_valid)
    );

    // Wraps modulo 2^ADDR_W so a buffer may straddle the top of RAM.
    assign ram_addr  = ADDR_W'(BASE_ADDR) + ADDR_W'(idx_q);
    assign ram_rd_en = (state_q == ST_REQ);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_FIN);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_char_buffer_reader.sv
// Bench for char_buffer_reader: RAM model, random data and backpressure,
// and an expected-character queue built from the buffer contents.
module tb_char_buffer_reader;

    localparam int BASE   = 1500;
    localparam int LEN    = 108;
    localparam int AW     = 12;
    localparam int W_BASE = 4094;
    localparam int W_LEN  = 4;

`ifdef CHAR_READER_NUL_STOP_EN
    localparam int NUL_EXP_HS = 4;
`else
    localparam int NUL_EXP_HS = 108;
`endif

    logic          clock;
    logic          reset;
    logic          start;
    logic          busy;
    logic          done;
    logic          ram_rd_en;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_data;
    logic [7:0]    char_data;
    logic          char_valid;
    logic          char_ready;
    logic [7:0]    char_index;
    logic [2:0]    dbg_state;

    logic          w_start;
    logic          w_busy;
    logic          w_done;
    logic          w_rd_en;
    logic [AW-1:0] w_ram_addr;
    logic [31:0]   w_ram_data;
    logic [7:0]    w_char_data;
    logic          w_valid;
    logic          w_ready;
    logic [7:0]    w_char_index;
    logic [2:0]    w_dbg_state;

    logic [31:0]   mem [0:4095];
    logic [15:0]   exp_q [$];

    int n_tests;
    int n_fail;
    int hs_cnt;
    int done_cnt;

    char_buffer_reader #(.BASE_ADDR(BASE), .BUF_LEN(LEN), .ADDR_W(AW)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .ram_rd_en  (ram_rd_en),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .char_data  (char_data),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .char_index (char_index),
        .dbg_state  (dbg_state)
    );

    char_buffer_reader #(.BASE_ADDR(W_BASE), .BUF_LEN(W_LEN), .ADDR_W(AW)) dut_wrap (
        .clock      (clock),
        .reset      (reset),
        .start      (w_start),
        .busy       (w_busy),
        .done       (w_done),
        .ram_rd_en  (w_rd_en),
        .ram_addr   (w_ram_addr),
        .ram_data   (w_ram_data),
        .char_data  (w_char_data),
        .char_valid (w_valid),
        .char_ready (w_ready),
        .char_index (w_char_index),
        .dbg_state  (w_dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous-read RAM: data for an address appears one edge later.
    always @(posedge clock) begin
        ram_data   <= mem[ram_addr];
        w_ram_data <= mem[w_ram_addr];
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every accepted character must be the next one expected.
    always @(negedge clock) begin
        if (reset) begin
            if (char_valid && char_ready) begin
                hs_cnt <= hs_cnt + 1;
                if (exp_q.size() == 0)
                    chk("char_unexpected", {16'h0, char_index, char_data}, 32'hffff_ffff);
                else
                    chk("char", {16'h0, char_index, char_data}, {16'h0, exp_q.pop_front()});
            end
            if (done)
                done_cnt <= done_cnt + 1;
        end
    end

    // ---------------- reference model ----------------
    task automatic fill(input int base, input int len, input int mode);
        logic [7:0] b;
        for (int i = 0; i < len; i++) begin
            case (mode)
                0:       b = 8'(8'h41 + (i % 26));
                1:       b = 8'($urandom_range(1, 255));
                default: b = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            endcase
            mem[(base + i) % 4096] = {24'($urandom), b};
        end
    endtask

    task automatic build_exp(input int base, input int len);
        logic [7:0] b;
        exp_q.delete();
        for (int i = 0; i < len; i++) begin
            b = mem[(base + i) % 4096][7:0];
`ifdef CHAR_READER_NUL_STOP_EN
            if (b == 8'h00) break;
`endif
            exp_q.push_back({8'(i), b});
        end
    endtask

    // ---------------- driver ----------------
    task automatic run_drain(input string tag, input int ready_pct, input bit poke,
                             input int bp_char, input bit timing);
        int         hold;
        int         stable_err;
        int         nneg;
        int         first_valid_neg;
        int         last_hs_neg;
        int         fin_neg;
        bit         fin;
        bit         chk_addr;
        logic [7:0] cap_d;
        logic [7:0] cap_i;
        hold = 0; stable_err = 0; fin = 0; chk_addr = 0;
        first_valid_neg = -1; last_hs_neg = -1; fin_neg = -1;
        cap_d = 8'h00; cap_i = 8'h00;
        hs_cnt = 0; done_cnt = 0;
        char_ready = 1'b0;
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        @(negedge clock);
        nneg = 1;
        chk({tag, "_req_addr"}, 32'(ram_addr), 32'(BASE));
        chk({tag, "_req_rd_en"}, 32'(ram_rd_en), 32'd1);
        for (int c = 0; c < 4000 && !fin; c++) begin
            @(posedge clock); #1;
            if (chk_addr) begin
                chk({tag, "_bp_next_addr"}, 32'(ram_addr), 32'(BASE + bp_char + 1));
                chk({tag, "_bp_next_rd_en"}, 32'(ram_rd_en), 32'd1);
                chk_addr = 0;
            end
            if (bp_char >= 0 && char_valid && char_index == 8'(bp_char) && hold < 10) begin
                if (hold == 0) begin
                    cap_d = char_data;
                    cap_i = char_index;
                end
                char_ready = 1'b0;
                hold++;
            end else if (bp_char >= 0 && hold == 10 && char_valid) begin
                char_ready = 1'b1;
                chk_addr = 1;
                hold = 11;
            end else begin
                char_ready = ($urandom_range(1, 100) <= ready_pct);
            end
            start = poke && char_valid && (char_index == 8'd3 || char_index == 8'd50);
            @(negedge clock);
            nneg++;
            if (hold > 0 && hold <= 10 && !char_ready) begin
                if (char_data !== cap_d || char_index !== cap_i || ram_rd_en !== 1'b0 ||
                    char_valid !== 1'b1)
                    stable_err++;
            end
            if (char_valid && first_valid_neg < 0) first_valid_neg = nneg;
            if (char_valid && char_ready) last_hs_neg = nneg;
            if (done) begin
                fin = 1;
                fin_neg = nneg;
            end
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, 32'(fin), 32'd1);
        @(negedge clock);
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
        repeat (3) @(negedge clock);
        chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        chk({tag, "_left_in_q"}, 32'(exp_q.size()), 32'd0);
        if (timing) begin
            chk({tag, "_first_valid"}, 32'(first_valid_neg), 32'd3);
            chk({tag, "_done_after_hs"}, 32'(fin_neg - last_hs_neg), 32'd1);
            chk({tag, "_total_cycles"}, 32'(fin_neg), 32'(3 * LEN + 1));
        end
        if (bp_char >= 0) begin
            chk({tag, "_stable"}, 32'(stable_err), 32'd0);
            chk({tag, "_hold_done"}, 32'(hold), 32'd11);
        end
        char_ready = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int  k;
        bit  found;
        bit  wdone;
        n_tests = 0; n_fail = 0; hs_cnt = 0; done_cnt = 0;
        start = 1'b0; char_ready = 1'b0; w_start = 1'b0; w_ready = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_en", 32'(ram_rd_en), 32'd0);
        chk("rst_valid", 32'(char_valid), 32'd0);
        chk("rst_addr", 32'(ram_addr), 32'(BASE));
        chk("rst_data", 32'(char_data), 32'd0);
        chk("rst_index", 32'(char_index), 32'd0);
        chk("rst_wrap_addr", 32'(w_ram_addr), 32'(W_BASE));
        @(posedge clock); #1 reset = 1'b1;
        repeat (2) @(posedge clock);

        // Basic drain with the alphabet pattern and ready held high.
        fill(BASE, LEN, 0);
        build_exp(BASE, LEN);
        run_drain("basic", 100, 1'b0, -1, 1'b1);
        chk("basic_count", 32'(hs_cnt), 32'(LEN));

        // Backpressure on character 5.
        fill(BASE, LEN, 1);
        build_exp(BASE, LEN);
        run_drain("bp", 100, 1'b0, 5, 1'b0);

        // Extra start pulses while busy, with random ready.
        fill(BASE, LEN, 1);
        build_exp(BASE, LEN);
        run_drain("busy_start", 70, 1'b1, -1, 1'b0);
        chk("busy_start_count", 32'(hs_cnt), 32'(LEN));

        // Reset during SEND of character 40.
        fill(BASE, LEN, 1);
        build_exp(BASE, LEN);
        done_cnt = 0;
        char_ready = 1'b1;
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        found = 0;
        for (int c = 0; c < 1000 && !found; c++) begin
            @(negedge clock);
            if (char_valid && char_index == 8'd40) found = 1;
        end
        chk("rst_mid_reached", 32'(found), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_valid", 32'(char_valid), 32'd0);
        chk("rst_mid_rd_en", 32'(ram_rd_en), 32'd0);
        chk("rst_mid_data", 32'(char_data), 32'd0);
        chk("rst_mid_index", 32'(char_index), 32'd0);
        chk("rst_mid_addr", 32'(ram_addr), 32'(BASE));
        repeat (3) @(negedge clock);
        chk("rst_mid_no_done", 32'(done_cnt), 32'd0);
        @(posedge clock); #1 reset = 1'b1;
        char_ready = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clock);
        build_exp(BASE, LEN);
        run_drain("after_rst", 100, 1'b0, -1, 1'b1);

        // NUL at character 4.
        fill(BASE, LEN, 1);
        mem[BASE + 4][7:0] = 8'h00;
        build_exp(BASE, LEN);
        run_drain("nul", 100, 1'b0, -1, 1'b0);
        chk("nul_count", 32'(hs_cnt), 32'(NUL_EXP_HS));

        // Random data, zeros possible, random ready.
        for (int r = 0; r < 2; r++) begin
            fill(BASE, LEN, 2);
            build_exp(BASE, LEN);
            run_drain("rand", $urandom_range(30, 90), 1'b0, -1, 1'b0);
        end

        // Address wrap on the second instance.
        fill(W_BASE, W_LEN, 1);
        w_ready = 1'b1;
        @(posedge clock); #1 w_start = 1'b1;
        @(posedge clock); #1 w_start = 1'b0;
        k = 0; wdone = 0;
        for (int c = 0; c < 100 && !wdone; c++) begin
            @(negedge clock);
            if (w_rd_en) begin
                if (k < W_LEN) chk("wrap_addr", 32'(w_ram_addr), 32'((W_BASE + k) % 4096));
                k++;
            end
            if (w_valid)
                chk("wrap_char", {24'h0, w_char_data},
                    {24'h0, mem[(W_BASE + int'(w_char_index)) % 4096][7:0]});
            if (w_done) wdone = 1;
        end
        chk("wrap_reads", 32'(k), 32'(W_LEN));
        chk("wrap_done", 32'(wdone), 32'd1);
        w_ready = 1'b0;

        repeat (2) @(posedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
